// File: rtl/tpu_host_sequencer.sv
// Host-side front end for the 2x2 systolic TPU: streams 8 load bytes onto the
// TPU pins, waits for done, captures 8 result bytes and replays them to the host.
module tpu_host_sequencer #(
  parameter int unsigned LOAD_BYTES   = 8,
  parameter int unsigned RESULT_BYTES = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_transpose,
  input  logic       cfg_activation,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] tpu_ui_in,
  output logic [7:0] tpu_uio_in,
  input  logic [7:0] tpu_uo_out,
  input  logic [7:0] tpu_uio_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

  localparam logic [2:0]       LoadLast = 3'(LOAD_BYTES - 1);
  localparam logic [2:0]       ResLast  = 3'(RESULT_BYTES - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       ui_q, ui_d;
  logic             load_en_q, load_en_d;
  logic             cfg_t_q, cfg_t_d;
  logic             cfg_a_q, cfg_a_d;
  logic             terr_q, terr_d;
  logic             in_ready_q, in_ready_d;
  logic [7:0]       res_buf_q [RESULT_BYTES];
  logic [7:0]       res_buf_d [RESULT_BYTES];

  // Only the done bit of uio_out matters here.
  logic unused_uio;
  assign unused_uio = ^tpu_uio_out[6:0];

  // Next-state logic for the job sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    ui_d      = ui_q;
    load_en_d = 1'b0;
    cfg_t_d   = cfg_t_q;
    cfg_a_d   = cfg_a_q;
    terr_d    = terr_q;
    res_buf_d = res_buf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          cfg_t_d   = cfg_transpose;
          cfg_a_d   = cfg_activation;
          terr_d    = 1'b0;
          ui_d      = in_data;
          load_en_d = 1'b1;
          cnt_d     = 3'd1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (in_valid && in_ready_q) begin
          ui_d      = in_data;
          load_en_d = 1'b1;
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == LoadLast) begin
            cnt_d   = 3'd0;
            wait_d  = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (tpu_uio_out[7]) begin
          // The done cycle already carries result byte 0.
          res_buf_d[0] = tpu_uo_out;
          cnt_d        = 3'd1;
          state_d      = StCapture;
        end else if (wait_q == WaitLast) begin
          terr_d = 1'b1;
          for (int i = 0; i < RESULT_BYTES; i++) res_buf_d[i] = 8'h00;
          cfg_t_d = 1'b0;
          cfg_a_d = 1'b0;
          wait_d  = '0;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StCapture: begin
        // TPU result timing is fixed, so capture never waits on the host.
        res_buf_d[cnt_q] = tpu_uo_out;
        cnt_d            = cnt_q + 3'd1;
        if (cnt_q == ResLast) begin
          cnt_d   = 3'd0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == ResLast) begin
            cnt_d   = 3'd0;
            cfg_t_d = 1'b0;
            cfg_a_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle) || (state_d == StLoad);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      wait_q     <= '0;
      ui_q       <= 8'h00;
      load_en_q  <= 1'b0;
      cfg_t_q    <= 1'b0;
      cfg_a_q    <= 1'b0;
      terr_q     <= 1'b0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < RESULT_BYTES; i++) res_buf_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      ui_q       <= ui_d;
      load_en_q  <= load_en_d;
      cfg_t_q    <= cfg_t_d;
      cfg_a_q    <= cfg_a_d;
      terr_q     <= terr_d;
      in_ready_q <= in_ready_d;
      res_buf_q  <= res_buf_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    in_ready    = in_ready_q;
    tpu_ui_in   = ui_q;
    tpu_uio_in  = {5'b00000, cfg_a_q, cfg_t_q, load_en_q};
    out_valid   = (state_q == StDrain);
    out_data    = (state_q == StDrain) ? res_buf_q[cnt_q] : 8'h00;
    busy        = (state_q != StIdle);
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed self-checking bench for tpu_host_sequencer; the TPU side is driven
// from the bench with hand-chosen done timing and result bytes.
module tb_tpu_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_transpose, cfg_activation;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [7:0] tpu_ui_in, tpu_uio_in, tpu_uo_out, tpu_uio_out;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       busy, timeout_err;

  tpu_host_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_transpose  (cfg_transpose),
    .cfg_activation (cfg_activation),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .tpu_ui_in      (tpu_ui_in),
    .tpu_uio_in     (tpu_uio_in),
    .tpu_uo_out     (tpu_uo_out),
    .tpu_uio_out    (tpu_uio_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] LoadId = 64'h01000001_05060708;
  localparam logic [63:0] ResId  = 64'h05000600_07000800;
  localparam logic [63:0] ResAlt = 64'h11223344_55667788;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cfg_bad = 0;
  logic [1:0] exp_cfg = 2'b00;
  logic [7:0] pul_q [$];
  int         pul_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Load pulses and config pins observed away from the active edge.
  always @(negedge clk) begin
    if (tpu_uio_in[0]) begin
      pul_q.push_back(tpu_ui_in);
      pul_cyc.push_back(cyc);
    end
    if (rst_n && tpu_uio_in[7:1] !== (busy ? {5'b00000, exp_cfg} : 7'h00)) cfg_bad <= cfg_bad + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_job(input logic [63:0] bytes, input bit gapped, input bit toggle_cfg);
    int i = 0;
    int n = 0;
    while (i < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (gapped && (n % 2 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = bytes[63-8*i -: 8];
      end
      if (toggle_cfg && i > 0) begin
        cfg_transpose  = ~cfg_transpose;
        cfg_activation = ~cfg_activation;
      end
      if (in_valid && in_ready) i++;
    end
    check_eq("bytes_accepted", 64'(i), 64'd8);
  endtask

  task automatic tpu_respond(input logic [63:0] res, input int delay);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (delay) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      tpu_uio_out = (k == 0) ? 8'h80 : 8'h00;
      tpu_uo_out  = res[63-8*k -: 8];
    end
    @(negedge clk);
    tpu_uio_out = 8'h00;
    tpu_uo_out  = 8'h00;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (!out_valid && b < 50) begin
      @(negedge clk);
      b++;
    end
    check_eq("drain_start", 64'(out_valid), 64'd1);
  endtask

  task automatic collect(output logic [63:0] got, input int stall, input logic [7:0] first);
    int n = 0;
    int b = 0;
    int stall_bad = 0;
    got = '0;
    wait_drain();
    for (int s = 0; s < stall; s++) begin
      if (out_valid !== 1'b1 || out_data !== first) stall_bad++;
      @(negedge clk);
    end
    if (stall > 0) check_eq("stall_hold", 64'(stall_bad), 64'd0);
    while (n < 8 && b < 100) begin
      out_ready = 1'b1;
      if (out_valid) begin
        got[63-8*n -: 8] = out_data;
        n++;
      end
      @(negedge clk);
      b++;
    end
    out_ready = 1'b0;
    check_eq("idle_after_drain", {62'd0, out_valid, busy}, 64'd0);
  endtask

  task automatic check_pulses(input string tag, input logic [63:0] exp, input int span);
    logic [63:0] p = '0;
    check_eq({tag, "_pulse_cnt"}, 64'(pul_q.size()), 64'd8);
    if (pul_q.size() == 8) begin
      for (int k = 0; k < 8; k++) p[63-8*k -: 8] = pul_q[k];
      check_eq({tag, "_pulse_data"}, p, exp);
      check_eq({tag, "_pulse_span"}, 64'(pul_cyc[7] - pul_cyc[0]), 64'(span));
    end
    pul_q.delete();
    pul_cyc.delete();
  endtask

  initial begin
    logic [63:0] got;
    int n;
    bit saw_ov;
    rst_n = 1'b0;
    cfg_transpose = 1'b0; cfg_activation = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    tpu_uo_out = 8'h00; tpu_uio_out = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_pins", {48'd0, tpu_ui_in, tpu_uio_in}, 64'd0);
    check_eq("rst_out_data_terr", {55'd0, out_data, timeout_err}, 64'd0);
    rst_n = 1'b1;

    // Identity job, back-to-back bytes.
    send_job(LoadId, 1'b0, 1'b0);
    tpu_respond(ResId, 0);
    collect(got, 0, 8'h05);
    check_eq("id_results", got, ResId);
    check_pulses("id", LoadId, 7);

    // Gapped input.
    send_job(LoadId, 1'b1, 1'b0);
    tpu_respond(ResId, 2);
    collect(got, 0, 8'h05);
    check_eq("gap_results", got, ResId);
    check_pulses("gap", LoadId, 14);

    // Output back-pressure.
    send_job(LoadId, 1'b0, 1'b0);
    tpu_respond(ResId, 3);
    collect(got, 10, 8'h05);
    check_eq("bp_results", got, ResId);
    check_pulses("bp", LoadId, 7);

    // Timeout: done never arrives.
    send_job(LoadId, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    saw_ov = 1'b0;
    while (busy && n < 200) begin
      if (out_valid) saw_ov = 1'b1;
      @(negedge clk);
      n++;
    end
    check_eq("to_wait_cycles", 64'(n), 64'd65);
    check_eq("to_err", 64'(timeout_err), 64'd1);
    check_eq("to_in_ready", 64'(in_ready), 64'd1);
    check_eq("to_no_out", {62'd0, saw_ov, out_valid}, 64'd0);
    check_pulses("to", LoadId, 7);

    // Config sampled at job start, toggled during LOAD.
    cfg_transpose = 1'b1; cfg_activation = 1'b1; exp_cfg = 2'b11;
    send_job(LoadId, 1'b0, 1'b1);
    check_eq("to_err_cleared", 64'(timeout_err), 64'd0);
    tpu_respond(ResId, 1);
    collect(got, 0, 8'h05);
    check_eq("cfg_results", got, ResId);
    check_pulses("cfg", LoadId, 7);

    // Async reset mid-drain at rd=3.
    cfg_transpose = 1'b1; cfg_activation = 1'b1; exp_cfg = 2'b11;
    send_job(LoadId, 1'b0, 1'b0);
    tpu_respond(ResAlt, 0);
    wait_drain();
    repeat (3) begin
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_eq("ar_rd3_data", {48'd0, out_data, tpu_uio_in}, {48'd0, 8'h44, 8'h06});
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_async_clear", {53'd0, out_valid, busy, tpu_uio_in}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_transpose = 1'b0; cfg_activation = 1'b0; exp_cfg = 2'b00;
    pul_q.delete();
    pul_cyc.delete();

    // Fresh job after reset.
    send_job(LoadId, 1'b0, 1'b0);
    tpu_respond(ResId, 0);
    collect(got, 0, 8'h05);
    check_eq("post_rst_results", got, ResId);
    check_pulses("post_rst", LoadId, 7);

    check_eq("cfg_pins_hold", 64'(cfg_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
